// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline types: reset PC default, BTB counter encoding, BTB entry layout.
package pipeline_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned TARGET_W  = 30;
    // Widest tag needed (4-entry table leaves 28 upper bits); smaller tags are zero-extended.
    localparam int unsigned TAG_W_MAX = 28;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [TARGET_W-1:0]  target;
        ctr_e                 ctr;
    } btb_entry_t;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        ctr_e r;
        r = c;
        if (taken) begin
            if (c != STRONG_T) begin
                r = ctr_e'(2'(c + 2'd1));
            end
        end else begin
            if (c != STRONG_NT) begin
                r = ctr_e'(2'(c - 2'd1));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer: combinational lookup port, registered update port.
// Only built when PC_PREDICTOR_BTB_EN is defined.
`ifdef PC_PREDICTOR_BTB_EN
module btb_table
    import pipeline_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lkp_pc,
    output logic        lkp_taken_c,
    output logic [31:0] lkp_target_c,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int unsigned IDX_W     = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_SHIFT = IDX_W + 2;

    localparam btb_entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};

    btb_entry_t             tbl_q [BTB_ENTRIES];
    btb_entry_t             tbl_d [BTB_ENTRIES];
    btb_entry_t             lkp_ent;
    btb_entry_t             upd_ent;
    logic [IDX_W-1:0]       lkp_idx;
    logic [IDX_W-1:0]       upd_idx;
    logic [TAG_W_MAX-1:0]   lkp_tag;
    logic [TAG_W_MAX-1:0]   upd_tag;
    logic                   lkp_hit;
    logic                   upd_hit;
    logic                   unused_lsb;

    // Word-aligned addresses: the byte-offset bits carry no information.
    assign unused_lsb = ^{lkp_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    // Index/tag split of lookup and update addresses.
    always_comb begin
        lkp_idx = lkp_pc[TAG_SHIFT-1:2];
        upd_idx = upd_pc[TAG_SHIFT-1:2];
        lkp_tag = TAG_W_MAX'(lkp_pc >> TAG_SHIFT);
        upd_tag = TAG_W_MAX'(upd_pc >> TAG_SHIFT);
    end

    // Lookup against current (pre-update) contents.
    always_comb begin
        lkp_ent      = tbl_q[lkp_idx];
        lkp_hit      = lkp_ent.valid && (lkp_ent.tag == lkp_tag);
        lkp_taken_c  = lkp_hit && (lkp_ent.ctr inside {WEAK_T, STRONG_T});
        lkp_target_c = lkp_hit ? {lkp_ent.target, 2'b00} : 32'h0000_0000;
    end

    // Training: strengthen/weaken on hit, allocate weakly-taken on taken miss.
    always_comb begin
        tbl_d   = tbl_q;
        upd_ent = tbl_q[upd_idx];
        upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);
        if (upd_valid) begin
            if (upd_hit) begin
                tbl_d[upd_idx].ctr = ctr_next(upd_ent.ctr, upd_taken);
                if (upd_taken) begin
                    tbl_d[upd_idx].target = upd_target[31:2];
                end
            end else if (upd_taken) begin
                tbl_d[upd_idx] = '{valid: 1'b1, tag: upd_tag, target: upd_target[31:2], ctr: WEAK_T};
            end
        end
    end

    // Table storage; reset clears valids and parks counters at weakly not-taken.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
            if (rst) begin
                tbl_q[i] <= RST_ENTRY;
            end else begin
                tbl_q[i] <= tbl_d[i];
            end
        end
    end

endmodule
`endif

// File: rtl/pc_predictor.sv
// Fetch PC generator with optional BTB-based next-PC prediction.
// Define PC_PREDICTOR_BTB_EN to build the BTB; otherwise fetch is strictly sequential.
module pc_predictor
    import pipeline_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirectValid,
    input  logic [31:0] correctPC,
    input  logic        updValid,
    input  logic [31:0] updPC,
    input  logic        updTaken,
    input  logic [31:0] updTarget,
    output logic [31:0] predictPC,
    output logic        predictTaken,
    output logic [31:0] predictTarget
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        pred_taken_c;
    logic [31:0] pred_target_c;
    logic        unused_lsb;

    assign unused_lsb = ^correctPC[1:0];

`ifdef PC_PREDICTOR_BTB_EN
    btb_table #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .lkp_pc       (pc_q),
        .lkp_taken_c  (pred_taken_c),
        .lkp_target_c (pred_target_c),
        .upd_valid    (updValid),
        .upd_pc       (updPC),
        .upd_taken    (updTaken),
        .upd_target   (updTarget)
    );
`else
    logic unused_upd;

    // No predictor: training port and table sizing have no effect.
    assign unused_upd    = ^{updValid, updPC, updTaken, updTarget, 7'(BTB_ENTRIES)};
    assign pred_taken_c  = 1'b0;
    assign pred_target_c = 32'h0000_0000;
`endif

    // Next fetch address: redirect beats stall beats prediction beats sequential.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (redirectValid) begin
            pc_d = {correctPC[31:2], 2'b00};
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken_c) begin
            pc_d = pred_target_c;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC & 32'hFFFF_FFFC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign predictPC     = pc_q;
    assign predictTaken  = pred_taken_c;
    assign predictTarget = pred_target_c;

endmodule

// File: tb/tb_pc_predictor.sv
// Scoreboard bench for pc_predictor: stimulus pushes model expectations, monitor compares.
module tb_pc_predictor;

    localparam int unsigned N      = 16;
    localparam int unsigned IDXB   = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef PC_PREDICTOR_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirectValid;
    logic [31:0] correctPC;
    logic        updValid;
    logic [31:0] updPC;
    logic        updTaken;
    logic [31:0] updTarget;
    logic [31:0] predictPC;
    logic        predictTaken;
    logic [31:0] predictTarget;

    always #5 clk = ~clk;

    pc_predictor #(
        .BTB_ENTRIES (N),
        .RESET_PC    (RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirectValid (redirectValid),
        .correctPC     (correctPC),
        .updValid      (updValid),
        .updPC         (updPC),
        .updTaken      (updTaken),
        .updTarget     (updTarget),
        .predictPC     (predictPC),
        .predictTaken  (predictTaken),
        .predictTarget (predictTarget)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        int          step;
    } exp_t;

    exp_t exp_q[$];
    bit   stim_done = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    // Reference model: plain arrays indexed by word address modulo table size.
    logic [31:0] m_pc;
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];

    task automatic m_reset();
        m_pc = RST_PC;
        for (int i = 0; i < int'(N); i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
            m_tag[i]   = 32'h0;
            m_tgt[i]   = 32'h0;
        end
    endtask

    task automatic m_lookup(input logic [31:0] pc, output bit hit, output bit tk, output logic [31:0] tgt);
        int          idx;
        logic [31:0] tg;
        idx = int'((pc >> 2) % N);
        tg  = pc >> (IDXB + 2);
        hit = m_valid[idx] && (m_tag[idx] == tg);
        tk  = hit && (m_ctr[idx] >= 2);
        tgt = hit ? m_tgt[idx] : 32'h0;
    endtask

    // One clock of stimulus: drive, record expected outputs of this cycle, advance the model.
    task automatic cyc(input bit r, input bit s, input bit rv, input logic [31:0] cp,
                       input bit uv, input logic [31:0] up, input bit ut, input logic [31:0] utg);
        bit          hit;
        bit          tk;
        logic [31:0] tgt;
        exp_t        e;
        int          idx;
        logic [31:0] tg;
        rst = r; stall = s; redirectValid = rv; correctPC = cp;
        updValid = uv; updPC = up; updTaken = ut; updTarget = utg;
        m_lookup(m_pc, hit, tk, tgt);
        e.pc = m_pc; e.taken = tk; e.target = tgt; e.step = step_no;
        exp_q.push_back(e);
        step_no++;
        if (r) begin
            m_reset();
        end else begin
            if (rv)       m_pc = cp & 32'hFFFF_FFFC;
            else if (!s)  m_pc = tk ? tgt : m_pc + 32'd4;
            if (uv && BTB_ON) begin
                idx = int'((up >> 2) % N);
                tg  = up >> (IDXB + 2);
                if (m_valid[idx] && m_tag[idx] == tg) begin
                    if (ut) begin
                        if (m_ctr[idx] < 3) m_ctr[idx]++;
                        m_tgt[idx] = utg & 32'hFFFF_FFFC;
                    end else if (m_ctr[idx] > 0) begin
                        m_ctr[idx]--;
                    end
                end else if (ut) begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = tg;
                    m_tgt[idx]   = utg & 32'hFFFF_FFFC;
                    m_ctr[idx]   = 2;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic redirect(input logic [31:0] cp);
        cyc(0, 0, 1, cp, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, step, act, exp);
        end
    endtask

    // Monitor: every mid-cycle the DUT presents a fetch address; compare against the queue head.
    initial begin : monitor
        exp_t        e;
        int unsigned guard;
        bit          mon_done;
        guard    = 0;
        mon_done = 1'b0;
        while (!mon_done) begin
            @(negedge clk);
            guard++;
            if (guard > 20000) begin
                errors++;
                $display("FAIL timeout: stimulus did not complete, pending=%0d required=0", exp_q.size());
                mon_done = 1'b1;
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("predictPC",     e.step, predictPC,            e.pc);
                chk("predictTaken",  e.step, 32'(predictTaken),    32'(e.taken));
                chk("predictTarget", e.step, predictTarget,        e.target);
            end else if (stim_done) begin
                mon_done = 1'b1;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin : stimulus
        logic [31:0] cp;
        logic [31:0] up;
        logic [31:0] utg;
        rst = 1'b1; stall = 1'b0; redirectValid = 1'b0; correctPC = 32'h0;
        updValid = 1'b0; updPC = 32'h0; updTaken = 1'b0; updTarget = 32'h0;
        m_reset();
        @(posedge clk);
        #1;

        // Reset with a pending update: nothing allocated, then sequential fetch 0,4,8,C.
        cyc(1, 0, 0, 32'h0, 1, 32'h4, 1, 32'h300);
        idle(4);

        // Train 0x10 -> 0x100, then fetch through it.
        cyc(0, 0, 1, 32'h0, 1, 32'h10, 1, 32'h100);
        idle(7);

        // Two not-taken updates drive the counter to 00: 0x10 falls through to 0x14.
        cyc(0, 0, 0, 32'h0, 1, 32'h10, 0, 32'h0);
        cyc(0, 0, 0, 32'h0, 1, 32'h10, 0, 32'h0);
        redirect(32'h10);
        idle(3);

        // Lookup and update of the same entry in one cycle sees old contents.
        redirect(32'hC);
        idle(1);
        cyc(0, 0, 0, 32'h0, 1, 32'h10, 1, 32'h180);
        idle(2);

        // Redirect wins over stall; stall alone holds.
        cyc(0, 1, 1, 32'h200, 0, 32'h0, 0, 32'h0);
        cyc(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        cyc(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        idle(1);

        // Low address bits of redirect are dropped.
        redirect(32'h203);
        idle(1);

        // Sequential wrap at the top of the address space.
        redirect(32'hFFFF_FFFC);
        idle(2);

        // Alias: 0x50 shares the index of 0x10 but must miss.
        cyc(0, 0, 0, 32'h0, 1, 32'h10, 1, 32'h103);
        redirect(32'h50);
        idle(2);
        redirect(32'h10);
        idle(2);

        // Randomized traffic over a small address window to get frequent hits and aliases.
        for (int i = 0; i < 500; i++) begin
            cp = 32'($urandom_range(0, 47)) << 2;
            if ($urandom_range(0, 15) == 0) cp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else cp = cp | 32'($urandom_range(0, 3));
            up  = 32'($urandom_range(0, 47)) << 2;
            utg = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 9) == 0),
                cp,
                ($urandom_range(0, 9) < 4),
                up,
                ($urandom_range(0, 2) != 0),
                utg);
        end
        idle(3);
        stim_done = 1'b1;
    end

endmodule
